// File: rtl/dma_register_file_pkg.sv
// Shared types and constants for the DMA register file.
// Command, mode, status and request byte layouts follow the 8237 map.
package dmaRegConfigPkg;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_AW       = 16;
  localparam int DW           = 8;

  localparam logic [2:0] OFF_CMD     = 3'd0;
  localparam logic [2:0] OFF_REQ     = 3'd1;
  localparam logic [2:0] OFF_SMASK   = 3'd2;
  localparam logic [2:0] OFF_MODE    = 3'd3;
  localparam logic [2:0] OFF_CLRBP   = 3'd4;
  localparam logic [2:0] OFF_MCLR    = 3'd5;
  localparam logic [2:0] OFF_CLRMASK = 3'd6;
  localparam logic [2:0] OFF_ALLMASK = 3'd7;

  typedef struct packed {
    logic dack_hi;
    logic dreq_lo;
    logic ext_write;
    logic rot_prio;
    logic comp_timing;
    logic ctrl_dis;
    logic c0_hold;
    logic mem2mem;
  } command_t;

  typedef struct packed {
    logic [1:0] xfer_mode;
    logic       addr_dec;
    logic       autoinit;
    logic [1:0] xfer_type;
    logic [1:0] ch;
  } mode_t;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] tc;
  } status_t;

  typedef struct packed {
    logic [4:0] rsvd;
    logic       val;
    logic [1:0] ch;
  } request_t;

  // BYTES: number of byte lanes in an address/count word
  function automatic int bytes_of(int aw);
    return aw / 8;
  endfunction

endpackage

// File: rtl/dma_register_file_if.sv
// Host bus and transfer-engine signals of the DMA register file.
// master drives the host/engine side, slave is the register file.
interface dma_register_file_if
  import dmaRegConfigPkg::*;
#(
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int ADDRESSWIDTH = DEF_AW
);
  logic                    cs;
  logic                    ior;
  logic                    iow;
  logic [3:0]              regAddr;
  logic [7:0]              dataIn;
  logic [7:0]              dataOut;
  logic                    xferStep;
  logic [1:0]              xferChannel;
  logic                    tempLoad;
  logic [7:0]              tempIn;
  logic [ADDRESSWIDTH-1:0] activeAddress;
  logic                    terminalCount;
  logic [7:0]              commandOut;
  logic [8*CHANNELS-1:0]   modeOut;
  logic [CHANNELS-1:0]     maskOut;
  logic [CHANNELS-1:0]     requestOut;
  logic [7:0]              temporaryOut;

  modport master (
    output cs, ior, iow, regAddr, dataIn,
    output xferStep, xferChannel, tempLoad, tempIn,
    input  dataOut, activeAddress, terminalCount,
    input  commandOut, modeOut, maskOut, requestOut,
    input  temporaryOut
  );

  modport slave (
    input  cs, ior, iow, regAddr, dataIn,
    input  xferStep, xferChannel, tempLoad, tempIn,
    output dataOut, activeAddress, terminalCount,
    output commandOut, modeOut, maskOut, requestOut,
    output temporaryOut
  );
endinterface

// File: rtl/dma_register_file_counter.sv
// Per-channel base/current address and word count with
// byte-lane host load, step update, TC detection and reload.
module dma_channel_counter
  import dmaRegConfigPkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          wr_cnt,
  input  logic [1:0]    bp,
  input  logic [7:0]    wr_data,
  input  logic          step,
  input  logic          dec,
  input  logic          hold,
  input  logic          autoinit,
  output logic [AW-1:0] cur_addr,
  output logic [AW-1:0] cur_count,
  output logic          tc
);
  logic [AW-1:0] base_addr_q, base_addr_d;
  logic [AW-1:0] base_count_q, base_count_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [AW-1:0] cur_count_q, cur_count_d;
  logic [AW-1:0] lane_mask, lane_data;

  always_comb begin
    lane_mask    = AW'(8'hFF) << {bp, 3'b000};
    lane_data    = AW'(wr_data) << {bp, 3'b000};
    base_addr_d  = base_addr_q;
    base_count_d = base_count_q;
    cur_addr_d   = cur_addr_q;
    cur_count_d  = cur_count_q;
    tc           = step && (cur_count_q == '0);
    if (step) begin
      if (!hold)
        cur_addr_d = dec ? cur_addr_q - AW'(1)
                         : cur_addr_q + AW'(1);
      cur_count_d = cur_count_q - AW'(1);
      if (tc && autoinit) begin
        cur_addr_d  = base_addr_q;
        cur_count_d = base_count_q;
      end
    end
    // a host byte write overrides the step for its own register
    if (wr_en && !wr_cnt) begin
      base_addr_d = (base_addr_q & ~lane_mask) | lane_data;
      cur_addr_d  = (cur_addr_q & ~lane_mask) | lane_data;
    end
    if (wr_en && wr_cnt) begin
      base_count_d = (base_count_q & ~lane_mask) | lane_data;
      cur_count_d  = (cur_count_q & ~lane_mask) | lane_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_addr_q  <= '0;
      base_count_q <= '0;
      cur_addr_q   <= '0;
      cur_count_q  <= '0;
    end else begin
      base_addr_q  <= base_addr_d;
      base_count_q <= base_count_d;
      cur_addr_q   <= cur_addr_d;
      cur_count_q  <= cur_count_d;
    end
  end

  assign cur_addr  = cur_addr_q;
  assign cur_count = cur_count_q;
endmodule

// File: rtl/dma_register_file.sv
// DMA controller register file: host byte-serial decode, byte
// pointer, control registers and one counter block per channel.
module dma_register_file
  import dmaRegConfigPkg::*;
#(
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int ADDRESSWIDTH = DEF_AW,
  parameter int DATAWIDTH    = DW
) (
  input logic           clk,
  input logic           reset,
  dma_register_file_if.slave bus
);
  localparam int BYTES = bytes_of(ADDRESSWIDTH);
  typedef logic [ADDRESSWIDTH-1:0] word_t;

  logic host_wr, host_rd, chan_acc, mclr, clr, step_ok;
  logic [1:0] ch_idx;
  logic [1:0] bp_q, bp_d;
  command_t cmd_q, cmd_d;
  mode_t mode_q [CHANNELS];
  mode_t mode_d [CHANNELS];
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [CHANNELS-1:0] req_q, req_d;
  logic [CHANNELS-1:0] tc_q, tc_d, tc_hit;
  logic [7:0] temp_q, temp_d;
  logic [DATAWIDTH-1:0] dout_q, dout_d, rd_val;
  logic tcp_q, tcp_d;
  word_t cur_addr [CHANNELS];
  word_t cur_count [CHANNELS];
  status_t status;
  request_t ctl;

  assign host_wr  = bus.cs && bus.iow;
  assign host_rd  = bus.cs && bus.ior && !bus.iow;
  assign ch_idx   = bus.regAddr[2:1];
  assign chan_acc = (host_wr || host_rd) && !bus.regAddr[3];
  assign mclr     = host_wr && bus.regAddr == {1'b1, OFF_MCLR};
  assign clr      = reset || mclr;
  assign step_ok  = bus.xferStep
                 && (int'(bus.xferChannel) < CHANNELS);
  assign ctl      = request_t'(bus.dataIn);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    dma_channel_counter #(.AW(ADDRESSWIDTH)) u_cnt (
      .clk      (clk),
      .reset    (clr),
      .wr_en    (host_wr && !bus.regAddr[3]
                 && ch_idx == 2'(i)),
      .wr_cnt   (bus.regAddr[0]),
      .bp       (bp_q),
      .wr_data  (bus.dataIn),
      .step     (step_ok && bus.xferChannel == 2'(i)),
      .dec      (mode_q[i].addr_dec),
      .hold     ((i == 0) && cmd_q.mem2mem && cmd_q.c0_hold),
      .autoinit (mode_q[i].autoinit),
      .cur_addr (cur_addr[i]),
      .cur_count(cur_count[i]),
      .tc       (tc_hit[i])
    );
  end

  always_comb begin
    rd_val = '0;
    status = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      status.req[i] = req_q[i];
      status.tc[i]  = tc_q[i];
    end
    if (!bus.regAddr[3]) begin
      for (int i = 0; i < CHANNELS; i++)
        if (ch_idx == 2'(i))
          rd_val = 8'((bus.regAddr[0] ? cur_count[i]
                                      : cur_addr[i])
                      >> {bp_q, 3'b000});
    end else begin
      unique case (bus.regAddr[2:0])
        OFF_CMD:  rd_val = status;
        OFF_MCLR: rd_val = temp_q;
        default:  rd_val = '0;
      endcase
    end
  end

  always_comb begin
    bp_d   = bp_q;
    cmd_d  = cmd_q;
    mode_d = mode_q;
    mask_d = mask_q;
    req_d  = req_q;
    tc_d   = tc_q;
    temp_d = temp_q;
    dout_d = dout_q;
    tcp_d  = |tc_hit;
    if (chan_acc)
      bp_d = (bp_q == 2'(BYTES - 1)) ? 2'd0 : bp_q + 2'd1;
    if (host_rd)
      dout_d = rd_val;
    if (host_rd && bus.regAddr == {1'b1, OFF_CMD})
      tc_d = '0;
    if (host_wr && bus.regAddr[3]) begin
      unique case (bus.regAddr[2:0])
        OFF_CMD: cmd_d = command_t'(bus.dataIn);
        OFF_REQ:
          for (int i = 0; i < CHANNELS; i++)
            if (ctl.ch == 2'(i)) req_d[i] = ctl.val;
        OFF_SMASK:
          for (int i = 0; i < CHANNELS; i++)
            if (ctl.ch == 2'(i)) mask_d[i] = ctl.val;
        OFF_MODE:
          for (int i = 0; i < CHANNELS; i++)
            if (ctl.ch == 2'(i))
              mode_d[i] = mode_t'(bus.dataIn);
        OFF_CLRBP:   bp_d = '0;
        OFF_CLRMASK: mask_d = '0;
        OFF_ALLMASK: mask_d = bus.dataIn[CHANNELS-1:0];
        default: ;
      endcase
    end
    // TC overrides same-cycle status clear and host req/mask writes
    for (int i = 0; i < CHANNELS; i++) begin
      if (tc_hit[i]) begin
        tc_d[i]  = 1'b1;
        req_d[i] = 1'b0;
        if (!mode_q[i].autoinit) mask_d[i] = 1'b1;
      end
    end
    if (bus.tempLoad)
      temp_d = bus.tempIn;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      bp_q   <= '0;
      cmd_q  <= '0;
      mode_q <= '{default: '0};
      mask_q <= '1;
      req_q  <= '0;
      tc_q   <= '0;
      temp_q <= '0;
      dout_q <= '0;
      tcp_q  <= 1'b0;
    end else begin
      bp_q   <= bp_d;
      cmd_q  <= cmd_d;
      mode_q <= mode_d;
      mask_q <= mask_d;
      req_q  <= req_d;
      tc_q   <= tc_d;
      temp_q <= temp_d;
      dout_q <= dout_d;
      tcp_q  <= tcp_d;
    end
  end

  always_comb begin
    bus.modeOut       = '0;
    bus.activeAddress = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.modeOut[8*i +: 8] = mode_q[i];
      if (bus.xferChannel == 2'(i))
        bus.activeAddress = cur_addr[i];
    end
  end

  assign bus.dataOut       = dout_q;
  assign bus.terminalCount = tcp_q;
  assign bus.commandOut    = cmd_q;
  assign bus.maskOut       = mask_q;
  assign bus.requestOut    = req_q;
  assign bus.temporaryOut  = temp_q;
endmodule

// File: tb/tb_dma_register_file.sv
// Scoreboard bench for dma_register_file: directed scenarios and
// random traffic against an array-based register model.
module tb_dma_register_file;
  localparam int CH = 4;
  localparam int AW = 16;
  localparam int unsigned AM = 32'h0000_FFFF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset24 = 1'b1;
  always #5 clk = ~clk;

  dma_register_file_if #(.CHANNELS(CH), .ADDRESSWIDTH(AW)) bus ();
  dma_register_file #(.CHANNELS(CH), .ADDRESSWIDTH(AW), .DATAWIDTH(8))
    dut (.clk(clk), .reset(reset), .bus(bus));

  dma_register_file_if #(.CHANNELS(3), .ADDRESSWIDTH(24)) b24 ();
  dma_register_file #(.CHANNELS(3), .ADDRESSWIDTH(24), .DATAWIDTH(8))
    dut24 (.clk(clk), .reset(reset24), .bus(b24));

  int total = 0;
  int bad = 0;

  int unsigned m_ba[4], m_ca[4], m_bc[4], m_cc[4];
  bit m_mask[4], m_req[4], m_tc[4];
  int m_bp;
  logic [7:0] m_cmd, m_temp, m_dout;
  logic [7:0] m_mode[4];

  typedef struct {
    logic [7:0]  data;
    bit          tcp;
    logic [3:0]  mask;
    logic [3:0]  req;
    logic [7:0]  cmd;
    logic [7:0]  temp;
    logic [31:0] mode;
  } exp_t;
  exp_t sb[$];

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", n, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin
      m_ba[i] = 0; m_ca[i] = 0; m_bc[i] = 0; m_cc[i] = 0;
      m_mask[i] = 1; m_req[i] = 0; m_tc[i] = 0; m_mode[i] = 0;
    end
    m_bp = 0; m_cmd = 0; m_temp = 0; m_dout = 0;
  endfunction

  function automatic int unsigned put_byte(int unsigned v, logic [7:0] d);
    int unsigned sh = 8 * m_bp;
    return ((v & ~(32'hFF << sh)) | (int'(d) << sh)) & AM;
  endfunction

  function automatic logic [7:0] read_val(logic [3:0] a);
    int unsigned v;
    int ch = int'(a[2:1]);
    if (!a[3]) begin
      if (ch >= CH) return 8'h00;
      v = a[0] ? m_cc[ch] : m_ca[ch];
      return 8'((v >> (8 * m_bp)) & 32'hFF);
    end
    if (a[2:0] == 3'd0) begin
      v = 0;
      for (int i = 0; i < CH; i++) begin
        if (m_req[i]) v |= 1 << (4 + i);
        if (m_tc[i]) v |= 1 << i;
      end
      return 8'(v);
    end
    if (a[2:0] == 3'd5) return m_temp;
    return 8'h00;
  endfunction

  // one host/engine cycle: drive, advance model, queue expectation
  task automatic cyc(bit rst, bit c, bit w, bit r, logic [3:0] a,
                     logic [7:0] d, bit st, logic [1:0] sc,
                     bit tl = 0, logic [7:0] ti = 0);
    exp_t e;
    int unsigned na[4], nc[4];
    bit hit, ai, iswr, isrd;
    int ch;
    @(negedge clk);
    reset = rst; bus.cs = c; bus.iow = w; bus.ior = r;
    bus.regAddr = a; bus.dataIn = d; bus.xferStep = st;
    bus.xferChannel = sc; bus.tempLoad = tl; bus.tempIn = ti;
    iswr = c && w;
    isrd = c && r && !w;
    hit = 0;
    ch = int'(a[2:1]);
    if (rst || (iswr && a == 4'hD)) m_reset();
    else begin
      if (isrd) m_dout = read_val(a);
      na = m_ca; nc = m_cc;
      ai = m_mode[sc][4];
      if (st && int'(sc) < CH) begin
        hit = (m_cc[sc] == 0);
        if (!(sc == 0 && m_cmd[0] && m_cmd[1]))
          na[sc] = (m_mode[sc][5] ? m_ca[sc] - 1 : m_ca[sc] + 1) & AM;
        nc[sc] = (m_cc[sc] - 1) & AM;
        if (hit && ai) begin na[sc] = m_ba[sc]; nc[sc] = m_bc[sc]; end
      end
      if (iswr && !a[3] && ch < CH) begin
        if (a[0]) begin
          m_bc[ch] = put_byte(m_bc[ch], d); nc[ch] = put_byte(m_cc[ch], d);
        end else begin
          m_ba[ch] = put_byte(m_ba[ch], d); na[ch] = put_byte(m_ca[ch], d);
        end
      end
      m_ca = na; m_cc = nc;
      if (isrd && a == 4'h8)
        for (int i = 0; i < 4; i++) m_tc[i] = 0;
      if (iswr && a[3]) begin
        case (a[2:0])
          3'd0: m_cmd = d;
          3'd1: m_req[d[1:0]] = d[2];
          3'd2: m_mask[d[1:0]] = d[2];
          3'd3: m_mode[d[1:0]] = d;
          3'd4: m_bp = 0;
          3'd6: for (int i = 0; i < 4; i++) m_mask[i] = 0;
          3'd7: for (int i = 0; i < 4; i++) m_mask[i] = d[i];
          default: ;
        endcase
      end
      if ((iswr || isrd) && !a[3]) m_bp = (m_bp + 1) % (AW / 8);
      if (hit) begin
        m_tc[sc] = 1; m_req[sc] = 0;
        if (!ai) m_mask[sc] = 1;
      end
      if (tl) m_temp = ti;
    end
    e.data = m_dout; e.tcp = hit; e.cmd = m_cmd; e.temp = m_temp;
    for (int i = 0; i < 4; i++) begin
      e.mask[i] = m_mask[i]; e.req[i] = m_req[i];
      e.mode[8*i +: 8] = m_mode[i];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [3:0] a, logic [7:0] d);
    cyc(0, 1, 1, 0, a, d, 0, 0);
  endtask
  task automatic rd(logic [3:0] a);
    cyc(0, 1, 0, 1, a, 8'h00, 0, 0);
  endtask
  task automatic stp(logic [1:0] ch);
    cyc(0, 0, 0, 0, 4'h0, 8'h00, 1, ch);
  endtask
  task automatic idle();
    cyc(0, 0, 0, 0, 4'h0, 8'h00, 0, 0);
  endtask

  // monitor: every registered output checked the cycle after issue
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        @(negedge clk);
        chk("dataOut", bus.dataOut, e.data);
        chk("tcPulse", bus.terminalCount, e.tcp);
        chk("maskOut", bus.maskOut, e.mask);
        chk("requestOut", bus.requestOut, e.req);
        chk("commandOut", bus.commandOut, e.cmd);
        chk("temporaryOut", bus.temporaryOut, e.temp);
        chk("modeOut", bus.modeOut, e.mode);
      end
    end
  end

  task automatic c24(bit rst, bit w, bit r, logic [3:0] a,
                     logic [7:0] d, bit st, logic [1:0] sc);
    @(negedge clk);
    reset24 = rst; b24.cs = 1'b1; b24.iow = w; b24.ior = r;
    b24.regAddr = a; b24.dataIn = d; b24.xferStep = st;
    b24.xferChannel = sc; b24.tempLoad = 1'b0; b24.tempIn = 8'h00;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.cs = 0; bus.iow = 0; bus.ior = 0; bus.regAddr = 0;
    bus.dataIn = 0; bus.xferStep = 0; bus.xferChannel = 0;
    bus.tempLoad = 0; bus.tempIn = 0;
    b24.cs = 0; b24.iow = 0; b24.ior = 0; b24.regAddr = 0;
    b24.dataIn = 0; b24.xferStep = 0; b24.xferChannel = 0;
    b24.tempLoad = 0; b24.tempIn = 0;
    m_reset();

    cyc(1, 0, 0, 0, 4'h0, 8'h00, 0, 0);
    cyc(1, 0, 0, 0, 4'h0, 8'h00, 0, 0);
    chk("rst_mask", bus.maskOut, 4'hF);
    chk("rst_dout", bus.dataOut, 8'h00);
    chk("rst_addr", bus.activeAddress, 16'h0000);

    // byte-serial write/read of ch1 address
    wr(4'hC, 0); wr(4'h2, 8'h34); wr(4'h2, 8'h12);
    rd(4'h2); chk("ch1_b0", bus.dataOut, 8'h34);
    rd(4'h2); chk("ch1_b1", bus.dataOut, 8'h12);
    rd(4'h2); chk("bp_wrap", bus.dataOut, 8'h34);

    // terminal count without autoinit on ch2
    wr(4'hC, 0); wr(4'h5, 8'h01); wr(4'h5, 8'h00);
    wr(4'h4, 8'h00); wr(4'h4, 8'h10);
    wr(4'hB, 8'h02); wr(4'h9, 8'h06); wr(4'hA, 8'h02);
    chk("ch2_unmask", bus.maskOut, 4'hB);
    stp(2);
    chk("tc_early", bus.terminalCount, 1'b0);
    stp(2);
    chk("tc_pulse", bus.terminalCount, 1'b1);
    chk("tc_addr", bus.activeAddress, 16'h1002);
    chk("tc_mask", bus.maskOut, 4'hF);
    chk("tc_req", bus.requestOut, 4'h0);
    idle();
    chk("tc_once", bus.terminalCount, 1'b0);
    wr(4'hC, 0); rd(4'h5); chk("tc_cnt", bus.dataOut, 8'hFF);
    rd(4'h8); chk("status1", bus.dataOut, 8'h04);
    rd(4'h8); chk("status2", bus.dataOut, 8'h00);

    // autoinit, decrement on ch0
    wr(4'hC, 0); wr(4'h0, 8'h00); wr(4'h0, 8'h20);
    wr(4'h1, 8'h00); wr(4'h1, 8'h00);
    wr(4'hB, 8'h30); wr(4'hA, 8'h00);
    stp(0);
    chk("ai_tc", bus.terminalCount, 1'b1);
    chk("ai_addr", bus.activeAddress, 16'h2000);
    chk("ai_mask", bus.maskOut, 4'hE);

    // channel-0 address hold in mem-to-mem
    wr(4'hB, 8'h00); wr(4'hC, 0); wr(4'h1, 8'h05); wr(4'h1, 8'h00);
    wr(4'h8, 8'h03);
    stp(0); stp(0);
    chk("hold_addr", bus.activeAddress, 16'h2000);
    wr(4'hC, 0); rd(4'h1); chk("hold_cnt", bus.dataOut, 8'h03);
    wr(4'h8, 8'h00);

    // master clear abandons a partial write
    wr(4'hC, 0); wr(4'h6, 8'hAA); wr(4'hD, 8'h00);
    chk("mclr_mask", bus.maskOut, 4'hF);
    chk("mclr_cmd", bus.commandOut, 8'h00);
    wr(4'h6, 8'h77); wr(4'hC, 0);
    rd(4'h6); chk("mclr_byte0", bus.dataOut, 8'h77);

    // host count write collides with a step on ch3
    wr(4'hC, 0); wr(4'h7, 8'h10); wr(4'h7, 8'h00);
    cyc(0, 1, 1, 0, 4'h7, 8'h55, 1, 3);
    chk("col_addr", bus.activeAddress, 16'h0078);
    wr(4'hC, 0);
    rd(4'h7); chk("col_cnt0", bus.dataOut, 8'h55);
    rd(4'h7); chk("col_cnt1", bus.dataOut, 8'h00);

    // temporary register, and master clear beating tempLoad
    cyc(0, 0, 0, 0, 4'h0, 8'h00, 0, 0, 1, 8'hA5);
    rd(4'hD); chk("temp_rd", bus.dataOut, 8'hA5);
    cyc(0, 1, 1, 0, 4'hD, 8'h00, 0, 0, 1, 8'h5A);
    chk("temp_mclr", bus.temporaryOut, 8'h00);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] a;
      logic [7:0] d;
      bit c, w, r, st, tl, rs;
      a = 4'($urandom);
      d = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      c = ($urandom_range(0, 9) != 0);
      w = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 2) == 0);
      tl = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 499) == 0);
      if (a == 4'hD && w && $urandom_range(0, 15) != 0) a = 4'hC;
      cyc(rs, c, w, r, a, d, st, 2'($urandom), tl, 8'($urandom));
    end
    idle(); idle();
    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 0);

    // 24-bit, 3-channel build
    c24(1, 0, 0, 4'h0, 8'h00, 0, 0);
    chk("r24_mask", b24.maskOut, 3'b111);
    c24(0, 1, 0, 4'hC, 8'h00, 0, 0);
    c24(0, 1, 0, 4'h2, 8'h56, 0, 0);
    c24(0, 1, 0, 4'h2, 8'h34, 0, 0);
    c24(0, 1, 0, 4'h2, 8'h12, 0, 1);
    chk("a24_addr", b24.activeAddress, 24'h123456);
    c24(0, 0, 1, 4'h2, 8'h00, 0, 0); chk("a24_b0", b24.dataOut, 8'h56);
    c24(0, 0, 1, 4'h2, 8'h00, 0, 0); chk("a24_b1", b24.dataOut, 8'h34);
    c24(0, 0, 1, 4'h2, 8'h00, 0, 0); chk("a24_b2", b24.dataOut, 8'h12);
    c24(0, 0, 1, 4'h2, 8'h00, 0, 0); chk("a24_wrap", b24.dataOut, 8'h56);
    c24(0, 1, 0, 4'hC, 8'h00, 0, 0);
    c24(0, 1, 0, 4'h6, 8'hAB, 0, 0);
    c24(0, 1, 0, 4'hC, 8'h00, 0, 0);
    c24(0, 0, 1, 4'h6, 8'h00, 0, 0); chk("a24_noch", b24.dataOut, 8'h00);
    c24(0, 0, 1, 4'h2, 8'h00, 0, 0); chk("a24_bp", b24.dataOut, 8'h34);
    c24(0, 0, 0, 4'h0, 8'h00, 1, 3);
    c24(0, 0, 0, 4'h0, 8'h00, 0, 0);
    chk("a24_nostep", b24.terminalCount, 1'b0);
    c24(0, 0, 1, 4'h8, 8'h00, 0, 0); chk("a24_status", b24.dataOut, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
